hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1, data-memory load latency in cycles (1..15).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of front-end flush cycles per taken branch (1..7).
REQ-003 SHALL have `clk` as input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have `reset_n` as input, width 1: reset, synchronous, active-low.
REQ-005 SHALL have `id_rn`, `id_rm` as inputs, width 5 each: source registers of the instruction in ID.
REQ-006 SHALL have `id_uses_rn`, `id_uses_rm` as inputs, width 1 each: the ID instruction actually reads that source.
REQ-007 SHALL have `ex_rd` as input, width 5: destination register of the instruction in EX.
REQ-008 SHALL have `ex_memrd` and `ex_regwr` as inputs, width 1 each: the EX instruction is a load / writes the register file.
REQ-009 SHALL have `br_taken` as input, width 1: taken branch resolved in MEM, one-cycle pulse.
REQ-010 SHALL have `mul_start` and `mul_done` as inputs, width 1 each: ID issues a multi-cycle multiply / the multiplier finishes.
REQ-011 SHALL have `pc_en`, `ifid_en` as outputs, width 1 each: PC and IF/ID register write enables.
REQ-012 SHALL have `bubble_ex`, `flush_front` as outputs, width 1 each: zero the ID/EX control bits / invalidate IF/ID.
REQ-013 SHALL have `mul_abort` as output, width 1: kill the in-flight multiply.
REQ-014 SHALL have `state_o` as output, width 2: current FSM state, for debug.

Function
REQ-015 SHALL implement FSM states RUN=0, LDSTALL=1, FLUSH=2, MULWAIT=3.
REQ-016 SHALL raise load-use hazard = ex_memrd & ex_regwr & ex_rd!=31 & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)); register 31 (XZR) never hazards.
REQ-017 SHALL default to pc_en=1, ifid_en=1, bubble_ex=0, flush_front=0, mul_abort=0 in RUN with no event.
REQ-018 SHALL apply event priority in every state: br_taken > load-use hazard > mul_start.
REQ-019 SHALL, on hazard in RUN, drive pc_en=0, ifid_en=0, bubble_ex=1 in the same cycle (Mealy); stay in RUN if LOAD_LAT=1, else go to LDSTALL with a counter loaded to LOAD_LAT-1.
REQ-020 SHALL, in LDSTALL, hold pc_en=0, ifid_en=0, bubble_ex=1, decrement the counter each cycle, and go to RUN in the cycle after the counter reaches 1.
REQ-021 SHALL, on br_taken in any state, drive flush_front=1, bubble_ex=1, pc_en=1, ifid_en=1 that cycle and go to FLUSH with counter=FLUSH_CYCLES-1; if FLUSH_CYCLES=1, go to RUN.
REQ-022 SHALL, in FLUSH, hold flush_front=1, bubble_ex=1, pc_en=1 and return to RUN after the counter expires; a new br_taken during FLUSH reloads the counter.
REQ-023 SHALL, on br_taken during MULWAIT or LDSTALL, pulse mul_abort=1 (MULWAIT only) for that cycle, abandon the stall, and enter FLUSH.
REQ-024 SHALL, on mul_start in RUN with no hazard or branch, go to MULWAIT next cycle; the issue cycle itself does not stall.
REQ-025 SHALL, in MULWAIT, drive pc_en=0, ifid_en=0, bubble_ex=1 while mul_done=0; the cycle with mul_done=1 drives RUN defaults and returns to RUN.
REQ-026 SHALL ignore mul_done outside MULWAIT.
REQ-027 SHALL ignore mul_start outside RUN.

Reset
REQ-028 SHALL, with reset_n=0 at a clock edge, enter RUN, clear all counters and drive RUN defaults, including mid-stall or mid-flush; no mul_abort is generated by reset.

Configuration
REQ-029 SHALL, with HAZARD_PERF_EN defined, add 16-bit outputs `stall_cycles` (cycles with pc_en=0) and `flush_cycles` (cycles with flush_front=1), cleared by reset and saturating at 0xFFFF.
REQ-030 SHALL, without HAZARD_PERF_EN defined, not have those ports or counters, with all other behaviour identical.

Structure
REQ-031 SHALL place the state enum, the XZR constant (5'd31) and the LOAD_LAT/FLUSH_CYCLES defaults in the shared package `pipe_pkg`.
REQ-032 SHALL keep hazard detection in sub-module `loaduse_detect` (pure combinational compare).
REQ-033 SHALL keep the FSM, counters and perf counters in `hazard_ctrl`.

Verification
REQ-034 SHALL check: ex_memrd=1, ex_regwr=1, ex_rd=5, id_rn=5, id_uses_rn=1, LOAD_LAT=1 -> one cycle with pc_en=0, bubble_ex=1, state_o stays 0.
REQ-035 SHALL check: same stimulus with ex_rd=31, id_rn=31 -> no stall; id_uses_rn=0 with id_rn=5 -> no stall.
REQ-036 SHALL check: LOAD_LAT=3, hazard on reg 20 -> pc_en=0 for exactly 3 cycles, then RUN.
REQ-037 SHALL check: br_taken pulse, FLUSH_CYCLES=2 -> flush_front=1 for 2 cycles; second br_taken in cycle 2 -> flush extends 2 more cycles.
REQ-038 SHALL check: mul_start, mul_done after 4 cycles -> 4 stall cycles then pc_en=1; br_taken in MULWAIT cycle 2 -> mul_abort pulse, FLUSH.
REQ-039 SHALL check: reset_n=0 during LDSTALL -> next cycle state_o=0, pc_en=1; with HAZARD_PERF_EN defined, counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline hazard controller.
//   hz_state_e        : controller FSM encoding (RUN/LDSTALL/FLUSH/MULWAIT)
//   XZR               : zero register number, never a real dependency
//   LOAD_LAT_DEF      : default data-memory load latency
//   FLUSH_CYCLES_DEF  : default front-end flush length per taken branch
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MULWAIT = 2'd3
  } hz_state_e;

  localparam logic [4:0] XZR              = 5'd31;
  localparam int         LOAD_LAT_DEF     = 1;
  localparam int         FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/loaduse_detect.sv
// loaduse_detect: combinational load-use hazard compare.
// Ports:
//   id_rn, id_rm           : source registers of the ID instruction
//   id_uses_rn, id_uses_rm : ID instruction really reads that source
//   ex_rd                  : destination of the EX instruction
//   ex_memrd, ex_regwr     : EX instruction is a load / writes a register
//   hazard                 : ID needs a value the EX load has not produced yet
module loaduse_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_uses_rn,
  input  logic       id_uses_rm,
  input  logic [4:0] ex_rd,
  input  logic       ex_memrd,
  input  logic       ex_regwr,
  output logic       hazard
);

  logic w_rn_match;
  logic w_rm_match;

  assign w_rn_match = id_uses_rn && (id_rn == ex_rd);
  assign w_rm_match = id_uses_rm && (id_rm == ex_rd);

  // XZR reads as zero regardless of writes, so it never creates a dependency.
  assign hazard = ex_memrd && ex_regwr && (ex_rd != XZR) && (w_rn_match || w_rm_match);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller.
// Handles load-use stalls, taken-branch front-end flushes and multi-cycle
// multiply waits. Priority in every state: br_taken > load-use > mul_start.
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   id_rn/id_rm/id_uses_*     : ID source operands
//   ex_rd/ex_memrd/ex_regwr   : EX destination and load/write flags
//   br_taken                  : taken branch resolved in MEM (pulse)
//   mul_start, mul_done       : multiply issue / multiply completion
//   pc_en, ifid_en            : PC and IF/ID write enables
//   bubble_ex, flush_front    : zero ID/EX control / invalidate IF/ID
//   mul_abort                 : kill the in-flight multiply
//   state_o                   : current FSM state (debug)
// Optional build macro HAZARD_PERF_EN adds saturating 16-bit counters
//   stall_cycles (cycles with pc_en=0) and flush_cycles (flush_front=1).
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LOAD_LAT     = LOAD_LAT_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_uses_rn,
  input  logic       id_uses_rm,
  input  logic [4:0] ex_rd,
  input  logic       ex_memrd,
  input  logic       ex_regwr,
  input  logic       br_taken,
  input  logic       mul_start,
  input  logic       mul_done,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       bubble_ex,
  output logic       flush_front,
  output logic       mul_abort,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_cycles
`endif
);

  localparam logic [3:0] LD_RELOAD = 4'(LOAD_LAT - 1);
  localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);

  hz_state_e  r_state;
  hz_state_e  w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_hazard;
  logic       w_pc_en;
  logic       w_ifid_en;
  logic       w_bubble;
  logic       w_flush;
  logic       w_abort;

  loaduse_detect u_detect (
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_uses_rn (id_uses_rn),
    .id_uses_rm (id_uses_rm),
    .ex_rd      (ex_rd),
    .ex_memrd   (ex_memrd),
    .ex_regwr   (ex_regwr),
    .hazard     (w_hazard)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_en     = 1'b1;
    w_ifid_en   = 1'b1;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_abort     = 1'b0;

    if (br_taken) begin
      // A taken branch overrides any stall; the wrong-path multiply is killed.
      w_flush   = 1'b1;
      w_bubble  = 1'b1;
      w_abort   = (r_state == ST_MULWAIT);
      if (FLUSH_CYCLES == 1) begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 4'd0;
      end else begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = FL_RELOAD;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard) begin
            w_pc_en   = 1'b0;
            w_ifid_en = 1'b0;
            w_bubble  = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = ST_LDSTALL;
              w_cnt_nxt   = LD_RELOAD;
            end
          end else if (mul_start) begin
            w_state_nxt = ST_MULWAIT;
          end
        end
        ST_LDSTALL: begin
          w_pc_en   = 1'b0;
          w_ifid_en = 1'b0;
          w_bubble  = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 4'd0;
          end
        end
        ST_FLUSH: begin
          w_flush   = 1'b1;
          w_bubble  = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 4'd0;
          end
        end
        ST_MULWAIT: begin
          if (mul_done) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_pc_en   = 1'b0;
            w_ifid_en = 1'b0;
            w_bubble  = 1'b1;
          end
        end
      endcase
    end

    // While reset is held the pipeline sees plain RUN behaviour, no abort.
    if (!reset_n) begin
      w_pc_en   = 1'b1;
      w_ifid_en = 1'b1;
      w_bubble  = 1'b0;
      w_flush   = 1'b0;
      w_abort   = 1'b0;
    end
  end

  assign pc_en       = w_pc_en;
  assign ifid_en     = w_ifid_en;
  assign bubble_ex   = w_bubble;
  assign flush_front = w_flush;
  assign mul_abort   = w_abort;
  assign state_o     = r_state;

`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (!w_pc_en) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush)  r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rn, id_uses_rm, ex_memrd, ex_regwr;
  logic       br_taken, mul_start, mul_done;

  // Instance A: LOAD_LAT=1, instance B: LOAD_LAT=3; both FLUSH_CYCLES=2.
  logic       pc_en_a, ifid_en_a, bubble_a, flush_a, abort_a;
  logic [1:0] state_a;
  logic       pc_en_b, ifid_en_b, bubble_b, flush_b, abort_b;
  logic [1:0] state_b;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_a, fl_a, stall_b, fl_b;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_memrd(ex_memrd), .ex_regwr(ex_regwr),
    .br_taken(br_taken), .mul_start(mul_start), .mul_done(mul_done),
    .pc_en(pc_en_a), .ifid_en(ifid_en_a), .bubble_ex(bubble_a),
    .flush_front(flush_a), .mul_abort(abort_a), .state_o(state_a)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_a), .flush_cycles(fl_a)
`endif
  );

  hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_memrd(ex_memrd), .ex_regwr(ex_regwr),
    .br_taken(br_taken), .mul_start(mul_start), .mul_done(mul_done),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .bubble_ex(bubble_b),
    .flush_front(flush_b), .mul_abort(abort_b), .state_o(state_b)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_b), .flush_cycles(fl_b)
`endif
  );

  // Output vector: {pc_en, ifid_en, bubble_ex, flush_front, mul_abort, state[1:0]}
  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_HZ    = 7'b0010000;
  localparam logic [6:0] O_LDS   = 7'b0010001;
  localparam logic [6:0] O_BR    = 7'b1111000;
  localparam logic [6:0] O_FL    = 7'b1111010;
  localparam logic [6:0] O_MW    = 7'b0010011;
  localparam logic [6:0] O_MWD   = 7'b1100011;
  localparam logic [6:0] O_BRMW  = 7'b1111111;
  localparam logic [6:0] O_BRLD  = 7'b1111001;
  localparam logic [6:0] O_RSTLD = 7'b1100001;

  typedef struct {
    string      name;
    logic [6:0] exp_a;
    logic [6:0] exp_b;
    logic       perf_zero;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] got_a, got_b;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      got_a = {pc_en_a, ifid_en_a, bubble_a, flush_a, abort_a, state_a};
      got_b = {pc_en_b, ifid_en_b, bubble_b, flush_b, abort_b, state_b};
      checks++;
      if (got_a !== e.exp_a) begin
        errors++;
        $display("FAIL %s lat1: got %b expected %b", e.name, got_a, e.exp_a);
      end
      checks++;
      if (got_b !== e.exp_b) begin
        errors++;
        $display("FAIL %s lat3: got %b expected %b", e.name, got_b, e.exp_b);
      end
`ifdef HAZARD_PERF_EN
      if (e.perf_zero) begin
        checks++;
        if ({stall_a, fl_a, stall_b, fl_b} !== 64'd0) begin
          errors++;
          $display("FAIL %s perf: got %h %h %h %h expected 0", e.name, stall_a, fl_a, stall_b, fl_b);
        end
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input string n, input logic [6:0] a, input logic [6:0] b,
                     input logic pz = 1'b0);
    exp_t x;
    x.name = n; x.exp_a = a; x.exp_b = b; x.perf_zero = pz;
    q.push_back(x);
  endtask

  task automatic clr();
    id_rn = 5'd0; id_rm = 5'd0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
    ex_rd = 5'd0; ex_memrd = 1'b0; ex_regwr = 1'b0;
    br_taken = 1'b0; mul_start = 1'b0; mul_done = 1'b0;
  endtask

  task automatic haz(input logic [4:0] rd, input logic [4:0] rn, input logic urn,
                     input logic [4:0] rm, input logic urm);
    ex_memrd = 1'b1; ex_regwr = 1'b1; ex_rd = rd;
    id_rn = rn; id_uses_rn = urn; id_rm = rm; id_uses_rm = urm;
  endtask

  initial begin
    reset_n = 1'b0;
    clr();
    tick(); put("reset", O_RUN, O_RUN);
    tick(); reset_n = 1'b1; put("idle", O_RUN, O_RUN, 1'b1);

    // load-use on rn=5
    tick(); haz(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); put("ld_rn5", O_HZ, O_HZ);
    tick(); clr(); put("ld_rn5+1", O_RUN, O_LDS);
    tick(); put("ld_rn5+2", O_RUN, O_LDS);
    tick(); put("ld_rn5+3", O_RUN, O_RUN);
    // load-use on rm=20
    tick(); haz(5'd20, 5'd3, 1'b1, 5'd20, 1'b1); put("ld_rm20", O_HZ, O_HZ);
    tick(); clr(); put("ld_rm20+1", O_RUN, O_LDS);
    tick(); put("ld_rm20+2", O_RUN, O_LDS);
    tick(); put("ld_rm20+3", O_RUN, O_RUN);
    // non-hazards
    tick(); haz(5'd31, 5'd31, 1'b1, 5'd31, 1'b1); put("xzr", O_RUN, O_RUN);
    tick(); haz(5'd5, 5'd5, 1'b0, 5'd0, 1'b0); put("unused_rn", O_RUN, O_RUN);
    tick(); haz(5'd5, 5'd6, 1'b1, 5'd5, 1'b0); put("unused_rm", O_RUN, O_RUN);
    tick(); haz(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); ex_regwr = 1'b0; put("no_regwr", O_RUN, O_RUN);
    tick(); clr(); put("quiet", O_RUN, O_RUN);

    // single branch
    tick(); br_taken = 1'b1; put("br1", O_BR, O_BR);
    tick(); br_taken = 1'b0; put("br1+1", O_FL, O_FL);
    tick(); put("br1+2", O_RUN, O_RUN);
    // back-to-back branch reloads the flush
    tick(); br_taken = 1'b1; put("br2a", O_BR, O_BR);
    tick(); put("br2b", O_FL, O_FL);
    tick(); br_taken = 1'b0; put("br2b+1", O_FL, O_FL);
    tick(); put("br2b+2", O_RUN, O_RUN);
    // branch beats simultaneous hazard
    tick(); br_taken = 1'b1; haz(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); put("br_vs_haz", O_BR, O_BR);
    tick(); clr(); put("br_vs_haz+1", O_FL, O_FL);
    tick(); put("br_vs_haz+2", O_RUN, O_RUN);

    // multiply wait, done after 4 stall cycles
    tick(); mul_start = 1'b1; put("mul_issue", O_RUN, O_RUN);
    tick(); mul_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put("mul_wait", O_MW, O_MW);
      tick();
    end
    mul_done = 1'b1; put("mul_done", O_MWD, O_MWD);
    tick(); mul_done = 1'b0; put("mul_after", O_RUN, O_RUN);
    // mul_done outside MULWAIT ignored
    tick(); mul_done = 1'b1; put("done_in_run", O_RUN, O_RUN);
    tick(); mul_done = 1'b0; put("done_in_run+1", O_RUN, O_RUN);
    // branch aborts multiply
    tick(); mul_start = 1'b1; put("mul2_issue", O_RUN, O_RUN);
    tick(); mul_start = 1'b0; put("mul2_w1", O_MW, O_MW);
    tick(); br_taken = 1'b1; put("mul2_abort", O_BRMW, O_BRMW);
    tick(); br_taken = 1'b0; put("mul2_abort+1", O_FL, O_FL);
    tick(); put("mul2_abort+2", O_RUN, O_RUN);
    // mul_start ignored in FLUSH
    tick(); br_taken = 1'b1; put("ms_in_fl_br", O_BR, O_BR);
    tick(); br_taken = 1'b0; mul_start = 1'b1; put("ms_in_fl", O_FL, O_FL);
    tick(); mul_start = 1'b0; put("ms_in_fl+1", O_RUN, O_RUN);

    // branch during LDSTALL (lat3 only in LDSTALL)
    tick(); haz(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); put("ld3_haz", O_HZ, O_HZ);
    tick(); clr(); br_taken = 1'b1; put("ld3_br", O_BR, O_BRLD);
    tick(); br_taken = 1'b0; put("ld3_br+1", O_FL, O_FL);
    tick(); put("ld3_br+2", O_RUN, O_RUN);

    // reset during LDSTALL
    tick(); haz(5'd12, 5'd0, 1'b0, 5'd12, 1'b1); put("rst_haz", O_HZ, O_HZ);
    tick(); clr(); reset_n = 1'b0; put("rst_low", O_RUN, O_RSTLD);
    tick(); reset_n = 1'b1; put("rst_rel", O_RUN, O_RUN, 1'b1);
    tick(); put("rst_rel+1", O_RUN, O_RUN);

    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
